// File: rtl/jp_scanner_pkg.sv
// Shared types and constants for the NES-style joypad scanner.
// Imported by jp_scanner and jp_shift_ch.
package jp_scanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_CLK_LO = 3'd2,
        ST_CLK_HI = 3'd3,
        ST_DONE   = 3'd4
    } jp_state_e;

    // Pads pull the data line low for a pressed button; bit 0 (A) is shifted out first.
    localparam logic JP_PRESSED_LEVEL  = 1'b0;
    localparam logic JP_RELEASED_LEVEL = 1'b1;

    function automatic int unsigned jp_cnt_w(input int unsigned limit);
        if (limit > 32'd1) begin
            return $clog2(limit);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/jp_shift_ch.sv
// One joypad channel: 2-flop input synchroniser, serial-to-parallel shift register and
// button register. Defining JP_FILTER_EN adds a two-scan agreement filter.
module jp_shift_ch
    import jp_scanner_pkg::*;
#(
    parameter int unsigned BITS = 8
) (
    input  logic            clk_25,
    input  logic            rst,
    input  logic            data_in,
    input  logic            sample_en,
    input  logic            update_en,
    output logic [BITS-1:0] buttons_out
);

    logic            sync1_q;
    logic            sync2_q;
    logic [BITS-1:0] sr_q;
    logic [BITS-1:0] sr_d;
    logic [BITS:0]   sr_cat_s;
    logic [BITS-1:0] btn_q;
    logic [BITS-1:0] btn_d;
`ifdef JP_FILTER_EN
    logic [BITS-1:0] prev_q;
    logic [BITS-1:0] prev_d;
`endif

    // New bit enters at the top so the first-sampled bit ends up at index 0.
    assign sr_cat_s = {(sync2_q == JP_PRESSED_LEVEL), sr_q};

    // Shift, update and filter decisions.
    always_comb begin
        sr_d  = sr_q;
        btn_d = btn_q;
`ifdef JP_FILTER_EN
        prev_d = prev_q;
`endif
        if (sample_en) begin
            sr_d = sr_cat_s[BITS:1];
        end else begin
            sr_d = sr_q;
        end
        if (update_en) begin
`ifdef JP_FILTER_EN
            prev_d = sr_d;
            if (sr_d == prev_q) begin
                btn_d = sr_d;
            end else begin
                btn_d = btn_q;
            end
`else
            btn_d = sr_d;
`endif
        end else begin
            btn_d = btn_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            sync1_q <= JP_RELEASED_LEVEL;
            sync2_q <= JP_RELEASED_LEVEL;
            sr_q    <= {BITS{1'b0}};
            btn_q   <= {BITS{1'b0}};
`ifdef JP_FILTER_EN
            prev_q  <= {BITS{1'b0}};
`endif
        end else begin
            sync1_q <= data_in;
            sync2_q <= sync1_q;
            sr_q    <= sr_d;
            btn_q   <= btn_d;
`ifdef JP_FILTER_EN
            prev_q  <= prev_d;
`endif
        end
    end

    assign buttons_out = btn_q;

endmodule

// File: rtl/jp_scanner.sv
// NES-style serial joypad scanner: shared latch, per-channel clocks, periodic or requested scans.
// Optional JP_FILTER_EN makes each channel update only when two consecutive scans agree.
module jp_scanner
    import jp_scanner_pkg::*;
#(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned BITS        = 8,
    parameter int unsigned CLK_DIV     = 150,
    parameter int unsigned SCAN_PERIOD = 416667
) (
    input  logic                     clk_25,
    input  logic                     rst,
    input  logic                     scan_req,
    input  logic [CHANNELS-1:0]      jp_data_in,
    output logic                     jp_latch_out,
    output logic [CHANNELS-1:0]      jp_clk_out,
    output logic [CHANNELS*BITS-1:0] buttons_out,
    output logic                     valid_out,
    output logic                     busy_out
);

    localparam int unsigned PW = jp_cnt_w(2 * CLK_DIV);
    localparam int unsigned BW = jp_cnt_w(BITS);
    localparam logic [PW-1:0] LATCH_LAST = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] HALF_LAST  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(BITS - 1);

    jp_state_e             state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  latch_q, latch_d;
    logic [CHANNELS-1:0]   clk_q, clk_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  timer_fire_s;
    logic                  start_s;
    logic                  sample_s;
    logic                  update_s;

    // Free-running period timer; a period of 0 disables automatic scans.
    if (SCAN_PERIOD > 0) begin : g_timer
        localparam int unsigned TW = jp_cnt_w(SCAN_PERIOD);
        localparam logic [TW-1:0] TMR_LAST = TW'(SCAN_PERIOD - 1);
        logic [TW-1:0] tmr_q, tmr_d;

        always_comb begin
            if (tmr_q == TMR_LAST) begin
                tmr_d = {TW{1'b0}};
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end

        always_ff @(posedge clk_25 or posedge rst) begin
            if (rst) begin
                tmr_q <= {TW{1'b0}};
            end else begin
                tmr_q <= tmr_d;
            end
        end

        assign timer_fire_s = (tmr_q == TMR_LAST);
    end else begin : g_no_timer
        assign timer_fire_s = 1'b0;
    end

    // Requests only matter in IDLE, so anything arriving mid-scan is dropped.
    assign start_s = scan_req | timer_fire_s;

    // Scan sequencer: next state, phase/bit counters and sample strobes.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        sample_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_LATCH;
                    phase_d = {PW{1'b0}};
                    bit_d   = BW'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LATCH: begin
                if (phase_q == LATCH_LAST) begin
                    sample_s = 1'b1;
                    phase_d  = {PW{1'b0}};
                    if (BITS == 1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CLK_LO;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_CLK_LO: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = {PW{1'b0}};
                    state_d = ST_CLK_HI;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_CLK_HI: begin
                if (phase_q == HALF_LAST) begin
                    sample_s = 1'b1;
                    phase_d  = {PW{1'b0}};
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = ST_CLK_LO;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        latch_d  = (state_d == ST_LATCH);
        clk_d    = (state_d == ST_CLK_LO) ? {CHANNELS{1'b0}} : {CHANNELS{1'b1}};
        valid_d  = (state_d == ST_DONE);
        busy_d   = (state_d != ST_IDLE);
        update_s = (state_d == ST_DONE);
    end

    // Sequencer and output registers.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= {PW{1'b0}};
            bit_q   <= {BW{1'b0}};
            latch_q <= 1'b0;
            clk_q   <= {CHANNELS{1'b1}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            latch_q <= latch_d;
            clk_q   <= clk_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        jp_shift_ch #(
            .BITS (BITS)
        ) u_ch (
            .clk_25      (clk_25),
            .rst         (rst),
            .data_in     (jp_data_in[c]),
            .sample_en   (sample_s),
            .update_en   (update_s),
            .buttons_out (buttons_out[c*BITS +: BITS])
        );
    end

    assign jp_latch_out = latch_q;
    assign jp_clk_out   = clk_q;
    assign valid_out    = valid_q;
    assign busy_out     = busy_q;

endmodule

// File: tb/tb_jp_scanner.sv
// Directed bench for jp_scanner with a behavioural pad model and an expected-result queue.
module tb_jp_scanner;

    logic        clk_25 = 1'b0;
    logic        rst = 1'b1;
    logic        scan_req = 1'b0;
    logic [1:0]  jp_data_in;
    logic        jp_latch_out;
    logic [1:0]  jp_clk_out;
    logic [15:0] buttons_out;
    logic        valid_out;
    logic        busy_out;

    logic        scan_req_t = 1'b0;
    logic [1:0]  jp_data_t = 2'b11;
    logic        jp_latch_t;
    logic [1:0]  jp_clk_t;
    logic [15:0] buttons_t;
    logic        valid_t;
    logic        busy_t;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  pad_pat [2];
    logic [7:0]  pad_sr0 = 8'h00;
    logic [7:0]  pad_sr1 = 8'h00;
    logic [7:0]  m_prev [2];
    logic [7:0]  m_btn [2];
    logic [15:0] exp_q [$];

    jp_scanner #(.CHANNELS(2), .BITS(8), .CLK_DIV(4), .SCAN_PERIOD(0)) dut (
        .clk_25(clk_25), .rst(rst), .scan_req(scan_req), .jp_data_in(jp_data_in),
        .jp_latch_out(jp_latch_out), .jp_clk_out(jp_clk_out), .buttons_out(buttons_out),
        .valid_out(valid_out), .busy_out(busy_out));

    jp_scanner #(.CHANNELS(2), .BITS(8), .CLK_DIV(4), .SCAN_PERIOD(200)) dut_t (
        .clk_25(clk_25), .rst(rst), .scan_req(scan_req_t), .jp_data_in(jp_data_t),
        .jp_latch_out(jp_latch_t), .jp_clk_out(jp_clk_t), .buttons_out(buttons_t),
        .valid_out(valid_t), .busy_out(busy_t));

    always #20 clk_25 = ~clk_25;

    // Pad model: parallel load while latched, shift on each rising pad clock, 0 = pressed.
    always @(posedge jp_latch_out or posedge jp_clk_out[0]) begin
        if (jp_latch_out) pad_sr0 <= pad_pat[0];
        else              pad_sr0 <= {1'b0, pad_sr0[7:1]};
    end
    always @(posedge jp_latch_out or posedge jp_clk_out[1]) begin
        if (jp_latch_out) pad_sr1 <= pad_pat[1];
        else              pad_sr1 <= {1'b0, pad_sr1[7:1]};
    end
    assign jp_data_in = {~pad_sr1[0], ~pad_sr0[0]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_25);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_prev[c] = 8'h00;
            m_btn[c]  = 8'h00;
        end
    endtask

    task automatic push_exp();
        for (int c = 0; c < 2; c++) begin
`ifdef JP_FILTER_EN
            if (pad_pat[c] == m_prev[c]) m_btn[c] = pad_pat[c];
            m_prev[c] = pad_pat[c];
`else
            m_btn[c] = pad_pat[c];
`endif
        end
        exp_q.push_back({m_btn[1], m_btn[0]});
    endtask

    // One requested scan with waveform checks; extra_at > 0 re-requests mid-scan.
    task automatic run_scan(input int extra_at);
        int n, lat, clo, pulses, busy_bad, valid_n;
        logic prev_clk;
        push_exp();
        scan_req = 1'b1;
        step(1);
        scan_req = 1'b0;
        n = 1; lat = 0; clo = 0; pulses = 0; busy_bad = 0; valid_n = 0; prev_clk = 1'b1;
        while (valid_n == 0 && n <= 200) begin
            if (jp_latch_out) lat++;
            if (!jp_clk_out[0]) clo++;
            if (prev_clk && !jp_clk_out[0]) pulses++;
            if (jp_clk_out[1] !== jp_clk_out[0]) busy_bad++;
            prev_clk = jp_clk_out[0];
            if (!busy_out) busy_bad++;
            if (valid_out) begin
                valid_n = n;
            end else begin
                if (n == extra_at) scan_req = 1'b1;
                step(1);
                scan_req = 1'b0;
                n++;
            end
        end
        check("valid_latency", valid_n, 65);
        check("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) check("buttons", buttons_out, exp_q.pop_front());
        check("latch_cycles", lat, 8);
        check("clk_low_cycles", clo, 28);
        check("clk_pulses", pulses, 7);
        check("busy_clk_lockstep", busy_bad, 0);
        step(1);
        check("busy_after_done", busy_out, 0);
        check("valid_single", valid_out, 0);
    endtask

    task automatic idle_watch(input int cycles);
        int v, b;
        v = 0; b = 0;
        for (int i = 0; i < cycles; i++) begin
            step(1);
            if (valid_out) v++;
            if (busy_out) b++;
        end
        check("idle_valids", v, 0);
        check("idle_busy", b, 0);
    endtask

    initial begin
        int vcount, vat;
        pad_pat[0] = 8'h00;
        pad_pat[1] = 8'h00;
        model_reset();
        step(2);
        rst = 1'b0;
        check("rst_latch", jp_latch_out, 0);
        check("rst_clk", jp_clk_out, 2'b11);
        check("rst_buttons", buttons_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_busy", busy_out, 0);

        // Timer instance: request on the fire cycle gives one scan, next auto start 200 later.
        step(199);
        check("tmr_idle_before", busy_t, 0);
        scan_req_t = 1'b1;
        step(1);
        scan_req_t = 1'b0;
        check("tmr_start", busy_t, 1);
        vcount = 0; vat = 0;
        for (int m = 201; m <= 399; m++) begin
            step(1);
            if (valid_t) begin
                vcount++;
                vat = m;
            end
        end
        check("tmr_one_valid", vcount, 1);
        check("tmr_valid_edge", vat, 264);
        check("tmr_idle_pre_auto", busy_t, 0);
        step(1);
        check("tmr_auto_start", busy_t, 1);

        pad_pat[0] = 8'hA5;
        pad_pat[1] = 8'h00;
        run_scan(0);

        run_scan(10);
        idle_watch(80);

        pad_pat[1] = 8'h80;
        pad_pat[0] = 8'h01; run_scan(0);
        pad_pat[0] = 8'h01; run_scan(0);
        pad_pat[0] = 8'h03; run_scan(0);
        pad_pat[0] = 8'h01; run_scan(0);

        // Reset 30 cycles into a scan with everything pressed.
        pad_pat[0] = 8'hFF;
        pad_pat[1] = 8'hFF;
        scan_req = 1'b1;
        step(1);
        scan_req = 1'b0;
        step(29);
        rst = 1'b1;
        #1;
        check("abort_latch", jp_latch_out, 0);
        check("abort_clk", jp_clk_out, 2'b11);
        check("abort_buttons", buttons_out, 0);
        check("abort_valid", valid_out, 0);
        check("abort_busy", busy_out, 0);
        step(1);
        rst = 1'b0;
        model_reset();
        idle_watch(80);
        check("abort_buttons_held", buttons_out, 0);

        pad_pat[0] = 8'h5A;
        pad_pat[1] = 8'hC3;
        run_scan(0);
        check("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
